// File: rtl/alu_cmd_seq.sv
// Command sequencer for the 4-bit ALU: accepts an operation, drives registered operands,
// waits LAT settle cycles, captures result/flags and presents them until consumed.
module alu_cmd_seq #(
   parameter int LAT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_a,
   input  logic [3:0] in_b,
   input  logic [2:0] in_op,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_ctrl,
   input  logic [3:0] alu_res,
   input  logic       alu_car,
   input  logic       alu_of,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_res,
   output logic       out_car,
   output logic       out_of,
   output logic [2:0] out_op,
   output logic [7:0] op_cnt,
   output logic       sticky_of,
   input  logic       clr_sticky
);

   localparam logic [3:0] SETTLE = 4'(LAT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t     state;
   logic [3:0] cnt;
   logic       accept;
   logic       capture;
   logic       handshake;

   // Ready is a pure decode so a consumed response can be replaced on the same edge.
   assign in_ready  = (state == IDLE) | ((state == RESP) & out_ready);
   assign out_valid = (state == RESP);
   assign accept    = in_valid & in_ready;
   assign capture   = (state == EXEC) & (cnt == 4'd0);
   assign handshake = (state == RESP) & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         alu_a     <= 4'd0;
         alu_b     <= 4'd0;
         alu_ctrl  <= 3'd0;
         out_res   <= 4'd0;
         out_car   <= 1'b0;
         out_of    <= 1'b0;
         out_op    <= 3'd0;
         op_cnt    <= 8'd0;
         sticky_of <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_a    <= in_a;
                  alu_b    <= in_b;
                  alu_ctrl <= in_op;
                  cnt      <= SETTLE;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               if (capture) begin
                  out_res <= alu_res;
                  out_car <= alu_car;
                  out_of  <= alu_of;
                  out_op  <= alu_ctrl;
                  state   <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (handshake) begin
                  op_cnt <= op_cnt + 8'd1;
                  if (accept) begin
                     alu_a    <= in_a;
                     alu_b    <= in_b;
                     alu_ctrl <= in_op;
                     cnt      <= SETTLE;
                     state    <= EXEC;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // A fresh overflow outranks a clear arriving on the same edge.
         if (capture && alu_of) begin
            sticky_of <= 1'b1;
         end else if (clr_sticky) begin
            sticky_of <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: three instances (LAT 0, 3, 5) share stimulus, each with an ALU
// model attached, and are compared every cycle against a transaction-timestamp model.
module tb_alu_cmd_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_a = 4'd0;
   logic [3:0] in_b = 4'd0;
   logic [2:0] in_op = 3'd0;
   logic       out_ready = 1'b1;
   logic       clr_sticky = 1'b0;

   logic       in_ready_w  [3];
   logic [3:0] alu_a_w     [3];
   logic [3:0] alu_b_w     [3];
   logic [2:0] alu_ctrl_w  [3];
   logic       out_valid_w [3];
   logic [3:0] out_res_w   [3];
   logic       out_car_w   [3];
   logic       out_of_w    [3];
   logic [2:0] out_op_w    [3];
   logic [7:0] op_cnt_w    [3];
   logic       sticky_w    [3];

   int unsigned nerr = 0;
   int unsigned nchk = 0;
   int          cyc = 0;

   always #5 clk = ~clk;

   function automatic int lat_of(input int g);
      return (g == 0) ? 0 : ((g == 1) ? 3 : 5);
   endfunction

   // Team ALU behaviour: returns {carry, overflow, result}.
   function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
      int sa, sb, s;
      logic [3:0] r;
      logic c, o;
      sa = (a > 7) ? int'(a) - 16 : int'(a);
      sb = (b > 7) ? int'(b) - 16 : int'(b);
      c = 1'b0;
      o = 1'b0;
      r = 4'd0;
      case (op)
         3'd0: begin
            s = int'(a) + int'(b);
            r = 4'(s % 16);
            c = (s > 15);
            o = ((sa + sb) > 7) || ((sa + sb) < -8);
         end
         3'd1: begin
            s = int'(a) - int'(b);
            r = 4'((s + 16) % 16);
            c = (a >= b);
            o = ((sa - sb) > 7) || ((sa - sb) < -8);
         end
         3'd2: r = 4'(15 - int'(a));
         3'd3: r = a & b;
         3'd4: r = a | b;
         3'd5: r = a ^ b;
         3'd6: r = (a > b) ? 4'd1 : 4'd0;
         default: r = (a == b) ? 4'd1 : 4'd0;
      endcase
      return {c, o, r};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gi
      localparam int L = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
      logic [5:0] alu_o;
      assign alu_o = alu_f(alu_a_w[g], alu_b_w[g], alu_ctrl_w[g]);
      alu_cmd_seq #(.LAT(L)) dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .in_valid   (in_valid),
         .in_ready   (in_ready_w[g]),
         .in_a       (in_a),
         .in_b       (in_b),
         .in_op      (in_op),
         .alu_a      (alu_a_w[g]),
         .alu_b      (alu_b_w[g]),
         .alu_ctrl   (alu_ctrl_w[g]),
         .alu_res    (alu_o[3:0]),
         .alu_car    (alu_o[5]),
         .alu_of     (alu_o[4]),
         .out_valid  (out_valid_w[g]),
         .out_ready  (out_ready),
         .out_res    (out_res_w[g]),
         .out_car    (out_car_w[g]),
         .out_of     (out_of_w[g]),
         .out_op     (out_op_w[g]),
         .op_cnt     (op_cnt_w[g]),
         .sticky_of  (sticky_w[g]),
         .clr_sticky (clr_sticky)
      );
   end

   // Reference model: a command is outstanding until its due edge, then a response is held.
   bit         m_busy [3];
   int         m_due  [3];
   bit         m_resp [3];
   logic [3:0] m_a    [3];
   logic [3:0] m_b    [3];
   logic [2:0] m_op   [3];
   logic [3:0] m_res  [3];
   logic       m_car  [3];
   logic       m_of   [3];
   logic [2:0] m_oop  [3];
   logic [7:0] m_cnt  [3];
   logic       m_stk  [3];

   task automatic model_reset();
      for (int g = 0; g < 3; g++) begin
         m_busy[g] = 0; m_due[g] = 0; m_resp[g] = 0;
         m_a[g] = 4'd0; m_b[g] = 4'd0; m_op[g] = 3'd0;
         m_res[g] = 4'd0; m_car[g] = 1'b0; m_of[g] = 1'b0; m_oop[g] = 3'd0;
         m_cnt[g] = 8'd0; m_stk[g] = 1'b0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      string t;
      for (int g = 0; g < 3; g++) begin
         t = $sformatf("L%0d@%0d", lat_of(g), cyc);
         chk({t, ".out_valid"}, 32'(out_valid_w[g]), 32'(m_resp[g]));
         chk({t, ".in_ready"}, 32'(in_ready_w[g]),
             32'(!m_busy[g] && (!m_resp[g] || out_ready)));
         chk({t, ".alu_a"}, 32'(alu_a_w[g]), 32'(m_a[g]));
         chk({t, ".alu_b"}, 32'(alu_b_w[g]), 32'(m_b[g]));
         chk({t, ".alu_ctrl"}, 32'(alu_ctrl_w[g]), 32'(m_op[g]));
         chk({t, ".out_res"}, 32'(out_res_w[g]), 32'(m_res[g]));
         chk({t, ".out_car"}, 32'(out_car_w[g]), 32'(m_car[g]));
         chk({t, ".out_of"}, 32'(out_of_w[g]), 32'(m_of[g]));
         chk({t, ".out_op"}, 32'(out_op_w[g]), 32'(m_oop[g]));
         chk({t, ".op_cnt"}, 32'(op_cnt_w[g]), 32'(m_cnt[g]));
         chk({t, ".sticky_of"}, 32'(sticky_w[g]), 32'(m_stk[g]));
      end
   endtask

   // Advance one clock edge, update the model from the inputs seen at that edge, then check.
   task automatic step();
      bit acc [3];
      bit hs  [3];
      bit cap [3];
      logic [5:0] r;
      for (int g = 0; g < 3; g++) begin
         hs[g]  = m_resp[g] && out_ready;
         acc[g] = in_valid && !m_busy[g] && (!m_resp[g] || out_ready);
         cap[g] = m_busy[g] && (cyc + 1 == m_due[g]);
      end
      @(posedge clk);
      cyc++;
      if (rst_n) begin
         for (int g = 0; g < 3; g++) begin
            if (hs[g]) begin
               m_cnt[g]  = m_cnt[g] + 8'd1;
               m_resp[g] = 0;
            end
            r = alu_f(m_a[g], m_b[g], m_op[g]);
            if (cap[g]) begin
               m_resp[g] = 1;
               m_busy[g] = 0;
               m_res[g] = r[3:0]; m_car[g] = r[5]; m_of[g] = r[4]; m_oop[g] = m_op[g];
            end
            if (cap[g] && r[4]) m_stk[g] = 1'b1;
            else if (clr_sticky) m_stk[g] = 1'b0;
            if (acc[g]) begin
               m_busy[g] = 1;
               m_due[g]  = cyc + lat_of(g) + 1;
               m_a[g] = in_a; m_b[g] = in_b; m_op[g] = in_op;
            end
         end
      end
      #1;
      check_all();
   endtask

   // Single command from all-idle with out_ready=1; explicit expected response values.
   task automatic run_directed(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                               input logic [3:0] er, input logic ec, input logic eo);
      logic [7:0] c0 [3];
      for (int g = 0; g < 3; g++) c0[g] = op_cnt_w[g];
      out_ready = 1'b1;
      in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int j = 1; j <= 7; j++) begin
         step();
         for (int g = 0; g < 3; g++) begin
            chk($sformatf("dir.L%0d.valid_j%0d", lat_of(g), j), 32'(out_valid_w[g]),
                32'(j == lat_of(g) + 1));
            if (j == lat_of(g) + 1) begin
               chk($sformatf("dir.L%0d.res", lat_of(g)), 32'(out_res_w[g]), 32'(er));
               chk($sformatf("dir.L%0d.car", lat_of(g)), 32'(out_car_w[g]), 32'(ec));
               chk($sformatf("dir.L%0d.of", lat_of(g)), 32'(out_of_w[g]), 32'(eo));
               chk($sformatf("dir.L%0d.op", lat_of(g)), 32'(out_op_w[g]), 32'(op));
            end
         end
      end
      for (int g = 0; g < 3; g++)
         chk($sformatf("dir.L%0d.cnt", lat_of(g)), 32'(op_cnt_w[g]), 32'(c0[g] + 8'd1));
   endtask

   initial begin
      logic [7:0] held_cnt [3];
      logic [3:0] held_res [3];
      model_reset();
      #1;
      check_all();
      step();
      step();
      rst_n = 1'b1;
      step();

      // 7 + 1 overflows into the sign bit
      run_directed(4'd7, 4'd1, 3'd0, 4'd8, 1'b0, 1'b1);
      for (int g = 0; g < 3; g++) chk($sformatf("t1.L%0d.sticky", lat_of(g)), 32'(sticky_w[g]), 32'd1);
      run_directed(4'd5, 4'd3, 3'd1, 4'd2, 1'b1, 1'b0);
      run_directed(4'hC, 4'hA, 3'd5, 4'h6, 1'b0, 1'b0);

      // Response held while out_ready is low; in_a keeps changing and must be ignored.
      out_ready = 1'b0;
      in_a = 4'd3; in_b = 4'd4; in_op = 3'd4; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int j = 0; j < 6; j++) step();
      for (int g = 0; g < 3; g++) begin
         held_cnt[g] = op_cnt_w[g];
         held_res[g] = out_res_w[g];
      end
      in_valid = 1'b1;
      for (int j = 0; j < 10; j++) begin
         in_a = 4'($urandom_range(0, 15));
         step();
         for (int g = 0; g < 3; g++) begin
            chk($sformatf("hold.L%0d.in_ready", lat_of(g)), 32'(in_ready_w[g]), 32'd0);
            chk($sformatf("hold.L%0d.cnt", lat_of(g)), 32'(op_cnt_w[g]), 32'(held_cnt[g]));
            chk($sformatf("hold.L%0d.res", lat_of(g)), 32'(out_res_w[g]), 32'h7);
         end
      end
      in_a = 4'd9;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("rel.L%0d.cnt", lat_of(g)), 32'(op_cnt_w[g]), 32'(held_cnt[g] + 8'd1));
         chk($sformatf("rel.L%0d.alu_a", lat_of(g)), 32'(alu_a_w[g]), 32'd9);
      end
      for (int j = 0; j < 8; j++) step();

      // Clear while idle, then clear coinciding with the LAT=0 overflow capture.
      clr_sticky = 1'b1;
      step();
      clr_sticky = 1'b0;
      for (int g = 0; g < 3; g++) chk($sformatf("clr.L%0d.sticky", lat_of(g)), 32'(sticky_w[g]), 32'd0);
      in_a = 4'd6; in_b = 4'd6; in_op = 3'd0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      clr_sticky = 1'b1;
      step();
      clr_sticky = 1'b0;
      chk("clrcap.L0.sticky", 32'(sticky_w[0]), 32'd1);
      for (int j = 0; j < 8; j++) step();

      // Back-to-back AND stream from a clean count; every instance wraps op_cnt past 255.
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      step();
      rst_n = 1'b1;
      in_op = 3'd3; in_valid = 1'b1; out_ready = 1'b1;
      for (int j = 0; j < 1800; j++) begin
         in_a = 4'($urandom_range(0, 15));
         in_b = 4'($urandom_range(0, 15));
         step();
      end
      in_valid = 1'b0;
      for (int j = 0; j < 8; j++) step();

      // Asynchronous reset while the LAT=5 instance has two settle cycles left.
      in_a = 4'd7; in_b = 4'd7; in_op = 3'd0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int j = 0; j < 3; j++) step();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("arst.L%0d.valid", lat_of(g)), 32'(out_valid_w[g]), 32'd0);
         chk($sformatf("arst.L%0d.cnt", lat_of(g)), 32'(op_cnt_w[g]), 32'd0);
         chk($sformatf("arst.L%0d.alu_a", lat_of(g)), 32'(alu_a_w[g]), 32'd0);
         chk($sformatf("arst.L%0d.in_ready", lat_of(g)), 32'(in_ready_w[g]), 32'd1);
      end
      check_all();
      step();
      rst_n = 1'b1;
      for (int j = 0; j < 8; j++) step();
      run_directed(4'd2, 4'd9, 3'd6, 4'd0, 1'b0, 1'b0);

      // Random traffic on every input.
      for (int j = 0; j < 800; j++) begin
         in_valid   = 1'($urandom_range(0, 1));
         out_ready  = ($urandom_range(0, 3) != 0);
         clr_sticky = ($urandom_range(0, 7) == 0);
         in_a  = 4'($urandom_range(0, 15));
         in_b  = 4'($urandom_range(0, 15));
         in_op = 3'($urandom_range(0, 7));
         step();
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
